// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the execute-stage ALU slice: default datapath
// width, opcode tags carried alongside results, and the flag bundle that
// the flag generator produces and the result buffer stores.
// ---------------------------------------------------------------------------
package alu_pkg;

    // Default datapath width of the logic units and the adder.
    localparam int ALU_WIDTH = 32;

    // Width of the opcode tag travelling with each result.
    localparam int ALU_OPW = 3;

    // Opcode tags of the producing operation.
    typedef enum logic [ALU_OPW-1:0] {
        OP_AND = 3'd0,
        OP_OR  = 3'd1,
        OP_XOR = 3'd2,
        OP_ADD = 3'd3,
        OP_SUB = 3'd4,
        OP_NOP = 3'd7
    } alu_op_e;

    // Condition flags derived from a result word.
    typedef struct packed {
        logic zero;    // word == 0
        logic sign;    // most significant bit of the word
        logic parity;  // 1 when the word holds an odd number of ones
    } alu_flags_t;

    // All-clear flag bundle, used whenever no valid result is presented.
    localparam alu_flags_t ALU_FLAGS_NONE = '{zero: 1'b0, sign: 1'b0, parity: 1'b0};

endpackage : alu_pkg

// File: rtl/alu_result_buffer_if.sv
// ---------------------------------------------------------------------------
// alu_result_buffer_if
// Handshake bundle around the ALU result buffer.
//   in_*  : upstream ALU -> buffer (valid/ready, result word, opcode tag)
//   out_* : buffer -> writeback (valid/ready, head result, tag, flags)
// Modports:
//   slave  : the buffer itself (consumes in_*, produces out_*)
//   master : the surrounding pipeline (produces in_*, consumes out_*)
// ---------------------------------------------------------------------------
interface alu_result_buffer_if #(
    parameter int WIDTH = 32,
    parameter int OPW   = 3
);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_result;
    logic [OPW-1:0]   in_op;

    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_result;
    logic [OPW-1:0]   out_op;
    logic             out_zero;
    logic             out_sign;
    logic             out_parity;

    modport slave (
        input  in_valid,
        output in_ready,
        input  in_result,
        input  in_op,
        output out_valid,
        input  out_ready,
        output out_result,
        output out_op,
        output out_zero,
        output out_sign,
        output out_parity
    );

    modport master (
        output in_valid,
        input  in_ready,
        output in_result,
        output in_op,
        input  out_valid,
        output out_ready,
        input  out_result,
        input  out_op,
        input  out_zero,
        input  out_sign,
        input  out_parity
    );

endinterface : alu_result_buffer_if

// File: rtl/alu_flag_gen.sv
// ---------------------------------------------------------------------------
// alu_flag_gen
// Purely combinational zero/sign/parity generator for one WIDTH-bit word.
// Shared between the result buffer and the branch unit.
// Ports:
//   word  : input  WIDTH  word to classify
//   flags : output        {zero, sign, parity} of word
// ---------------------------------------------------------------------------
module alu_flag_gen
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic [WIDTH-1:0] word,
    output alu_flags_t       flags
);

    always_comb begin
        flags        = ALU_FLAGS_NONE;
        flags.zero   = (word == '0);
        flags.sign   = word[WIDTH-1];
        // XOR reduction: set when an odd number of bits are one.
        flags.parity = ^word;
    end

endmodule : alu_flag_gen

// File: rtl/alu_result_buffer.sv
// ---------------------------------------------------------------------------
// alu_result_buffer
// Execute-stage output FIFO between the ALU and writeback. Captures one
// result per cycle together with its opcode tag and the flags computed at
// capture time, and presents the oldest entry to writeback under a
// valid/ready handshake, so writeback stalls do not stall the ALU.
// Ports:
//   clk          : input         clock, all state changes on the rising edge
//   rst          : input         synchronous active-high reset
//   bus          : slave modport in_valid/in_ready/in_result/in_op and
//                                out_valid/out_ready/out_result/out_op/
//                                out_zero/out_sign/out_parity
//   result_count : output CNTW   results dequeued since reset (wraps)
// ---------------------------------------------------------------------------
module alu_result_buffer
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH,
    parameter int DEPTH = 2,
    parameter int OPW   = ALU_OPW,
    parameter int CNTW  = 16
) (
    input  logic                clk,
    input  logic                rst,
    alu_result_buffer_if.slave  bus,
    output logic [CNTW-1:0]     result_count
);

    localparam int PTRW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int OCCW = $clog2(DEPTH + 1);
    localparam logic [OCCW-1:0] OCC_FULL = OCCW'(DEPTH);

    // Control state (reset)
    logic [PTRW-1:0] wr_ptr;
    logic [PTRW-1:0] rd_ptr;
    logic [OCCW-1:0] occupancy;

    // Entry storage (never reset; occupancy alone decides what is live)
    logic [WIDTH-1:0] mem_result [DEPTH];
    logic [OPW-1:0]   mem_op     [DEPTH];
    alu_flags_t       mem_flags  [DEPTH];

    alu_flags_t in_flags;
    logic       full;
    logic       empty;
    logic       enq;
    logic       deq;

    alu_flag_gen #(
        .WIDTH (WIDTH)
    ) u_flag_gen (
        .word  (bus.in_result),
        .flags (in_flags)
    );

    assign full  = (occupancy == OCC_FULL);
    assign empty = (occupancy == '0);

    // Acceptance depends only on registered occupancy: a full buffer
    // refuses input even while writeback drains it in the same cycle.
    assign enq = bus.in_valid && !full;
    assign deq = !empty && bus.out_ready;

    // ---- capture stage: pointers, occupancy, completed-result counter ----
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            occupancy    <= '0;
            result_count <= '0;
        end else begin
            if (enq) begin
                wr_ptr <= wr_ptr + PTRW'(1);
            end
            if (deq) begin
                rd_ptr       <= rd_ptr + PTRW'(1);
                result_count <= result_count + CNTW'(1);
            end
            case ({enq, deq})
                2'b10:   occupancy <= occupancy + OCCW'(1);
                2'b01:   occupancy <= occupancy - OCCW'(1);
                default: occupancy <= occupancy;
            endcase
        end
    end

    // A write coincident with reset lands in storage but is never exposed,
    // because occupancy returns to zero on the same edge.
    always_ff @(posedge clk) begin
        if (enq) begin
            mem_result[wr_ptr] <= bus.in_result;
            mem_op[wr_ptr]     <= bus.in_op;
            mem_flags[wr_ptr]  <= in_flags;
        end
    end

    // ---- presentation stage: head entry, zeroed while empty ----
    always_comb begin
        bus.in_ready   = !full;
        bus.out_valid  = !empty;
        bus.out_result = '0;
        bus.out_op     = '0;
        bus.out_zero   = 1'b0;
        bus.out_sign   = 1'b0;
        bus.out_parity = 1'b0;
        if (!empty) begin
            bus.out_result = mem_result[rd_ptr];
            bus.out_op     = mem_op[rd_ptr];
            bus.out_zero   = mem_flags[rd_ptr].zero;
            bus.out_sign   = mem_flags[rd_ptr].sign;
            bus.out_parity = mem_flags[rd_ptr].parity;
        end
    end

    // Occupancy can never leave 0..DEPTH.
    assert property (@(posedge clk) occupancy <= OCC_FULL);

    // A stalled head entry holds still until writeback takes it.
    assert property (@(posedge clk) disable iff (rst)
        (bus.out_valid && !bus.out_ready) |=> $stable(bus.out_result) && $stable(bus.out_op));

endmodule : alu_result_buffer

// File: tb/tb_alu_result_buffer.sv
module tb_alu_result_buffer;
    import alu_pkg::*;

    localparam int DEPTH = 2;

    typedef struct {
        logic [31:0] res;
        logic [2:0]  op;
    } entry_t;

    typedef struct {
        logic        rst;
        logic        iv;
        logic [31:0] din;
        logic [2:0]  op;
        logic        ordy;
        logic        e_ovld;
        logic        e_irdy;
        logic [31:0] e_dout;
        logic [2:0]  e_op;
        logic        e_z;
        logic        e_s;
        logic        e_p;
        logic [15:0] e_cnt;
    } vec_t;

    logic        clk;
    logic        rst;
    logic [15:0] result_count;

    alu_result_buffer_if #(.WIDTH(32), .OPW(3)) bus ();

    alu_result_buffer #(
        .WIDTH (32),
        .DEPTH (DEPTH),
        .OPW   (3),
        .CNTW  (16)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus),
        .result_count (result_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    entry_t      q[$];
    logic [15:0] m_cnt = 16'd0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    endtask

    // Compare every DUT output against the queue model's view of the buffer.
    task automatic compare_model();
        entry_t h;
        logic   v;
        v = (q.size() != 0);
        h.res = 32'd0;
        h.op  = 3'd0;
        if (v) h = q[0];
        check("model out_valid", 32'(bus.out_valid), 32'(v));
        check("model in_ready", 32'(bus.in_ready), 32'(q.size() < DEPTH));
        check("model out_result", bus.out_result, h.res);
        check("model out_op", 32'(bus.out_op), 32'(h.op));
        check("model out_zero", 32'(bus.out_zero), 32'(v && (h.res == 32'd0)));
        check("model out_sign", 32'(bus.out_sign), 32'(v && (h.res >= 32'h8000_0000)));
        check("model out_parity", 32'(bus.out_parity), 32'(v && (($countones(h.res) % 2) == 1)));
        check("model result_count", 32'(result_count), 32'(m_cnt));
    endtask

    // Drive one cycle of inputs, advance the model across the edge, and
    // optionally compare against it just after the edge.
    task automatic cycle(input logic r, input logic iv, input logic [31:0] d,
                         input logic [2:0] o, input logic ordy, input bit chk);
        logic   m_ready;
        logic   m_valid;
        entry_t e;
        rst           = r;
        bus.in_valid  = iv;
        bus.in_result = d;
        bus.in_op     = o;
        bus.out_ready = ordy;
        m_ready = (q.size() < DEPTH);
        m_valid = (q.size() != 0);
        if (r) begin
            q.delete();
            m_cnt = 16'd0;
        end else begin
            if (m_valid && ordy) begin
                e = q.pop_front();
                m_cnt = m_cnt + 16'd1;
            end
            if (iv && m_ready) begin
                e.res = d;
                e.op  = o;
                q.push_back(e);
            end
        end
        @(posedge clk);
        #1;
        if (chk) compare_model();
    endtask

    vec_t vecs[13];

    initial begin
        logic        iv;
        logic [31:0] d;
        logic [2:0]  o;
        logic [15:0] cnt0;

        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_result = 32'd0;
        bus.in_op     = 3'd0;
        bus.out_ready = 1'b0;

        //           rst   iv    din           op      ordy  ovld  irdy  dout          op      z     s     p     cnt
        vecs[0]  = '{1'b1, 1'b0, 32'h0000_0000, OP_AND, 1'b0, 1'b0, 1'b1, 32'h0000_0000, 3'd0,   1'b0, 1'b0, 1'b0, 16'd0};
        vecs[1]  = '{1'b0, 1'b0, 32'h0000_0000, OP_AND, 1'b0, 1'b0, 1'b1, 32'h0000_0000, 3'd0,   1'b0, 1'b0, 1'b0, 16'd0};
        vecs[2]  = '{1'b0, 1'b1, 32'hFFFF_FFFF, OP_XOR, 1'b1, 1'b1, 1'b1, 32'hFFFF_FFFF, OP_XOR, 1'b0, 1'b1, 1'b0, 16'd0};
        vecs[3]  = '{1'b0, 1'b0, 32'h0000_0000, OP_AND, 1'b1, 1'b0, 1'b1, 32'h0000_0000, 3'd0,   1'b0, 1'b0, 1'b0, 16'd1};
        vecs[4]  = '{1'b0, 1'b1, 32'h0000_0000, OP_AND, 1'b0, 1'b1, 1'b1, 32'h0000_0000, OP_AND, 1'b1, 1'b0, 1'b0, 16'd1};
        vecs[5]  = '{1'b0, 1'b1, 32'h0000_0001, OP_OR,  1'b0, 1'b1, 1'b0, 32'h0000_0000, OP_AND, 1'b1, 1'b0, 1'b0, 16'd1};
        vecs[6]  = '{1'b0, 1'b1, 32'h1234_5678, OP_ADD, 1'b0, 1'b1, 1'b0, 32'h0000_0000, OP_AND, 1'b1, 1'b0, 1'b0, 16'd1};
        vecs[7]  = '{1'b0, 1'b1, 32'h1234_5678, OP_ADD, 1'b1, 1'b1, 1'b1, 32'h0000_0001, OP_OR,  1'b0, 1'b0, 1'b1, 16'd2};
        vecs[8]  = '{1'b0, 1'b0, 32'h0000_0000, OP_AND, 1'b1, 1'b0, 1'b1, 32'h0000_0000, 3'd0,   1'b0, 1'b0, 1'b0, 16'd3};
        vecs[9]  = '{1'b0, 1'b1, 32'hA5A5_A5A5, OP_SUB, 1'b0, 1'b1, 1'b1, 32'hA5A5_A5A5, OP_SUB, 1'b0, 1'b1, 1'b0, 16'd3};
        vecs[10] = '{1'b0, 1'b1, 32'h0000_0007, OP_AND, 1'b0, 1'b1, 1'b0, 32'hA5A5_A5A5, OP_SUB, 1'b0, 1'b1, 1'b0, 16'd3};
        vecs[11] = '{1'b1, 1'b1, 32'h8000_0000, OP_OR,  1'b1, 1'b0, 1'b1, 32'h0000_0000, 3'd0,   1'b0, 1'b0, 1'b0, 16'd0};
        vecs[12] = '{1'b0, 1'b0, 32'h0000_0000, OP_AND, 1'b0, 1'b0, 1'b1, 32'h0000_0000, 3'd0,   1'b0, 1'b0, 1'b0, 16'd0};

        // Directed table: reset, single pass, fill/full/drain, reset with pending entries.
        for (int i = 0; i < 13; i++) begin
            cycle(vecs[i].rst, vecs[i].iv, vecs[i].din, vecs[i].op, vecs[i].ordy, 1'b1);
            check($sformatf("vec%0d out_valid", i), 32'(bus.out_valid), 32'(vecs[i].e_ovld));
            check($sformatf("vec%0d in_ready", i), 32'(bus.in_ready), 32'(vecs[i].e_irdy));
            check($sformatf("vec%0d out_result", i), bus.out_result, vecs[i].e_dout);
            check($sformatf("vec%0d out_op", i), 32'(bus.out_op), 32'(vecs[i].e_op));
            check($sformatf("vec%0d out_zero", i), 32'(bus.out_zero), 32'(vecs[i].e_z));
            check($sformatf("vec%0d out_sign", i), 32'(bus.out_sign), 32'(vecs[i].e_s));
            check($sformatf("vec%0d out_parity", i), 32'(bus.out_parity), 32'(vecs[i].e_p));
            check($sformatf("vec%0d result_count", i), 32'(result_count), 32'(vecs[i].e_cnt));
        end

        // Back-to-back streaming of 100 random words, then drain.
        cnt0 = m_cnt;
        for (int i = 0; i < 100; i++) begin
            cycle(1'b0, 1'b1, $urandom, 3'($urandom_range(0, 4)), 1'b1, 1'b1);
            if (i > 0) check("stream no bubble", 32'(bus.out_valid), 32'd1);
        end
        cycle(1'b0, 1'b0, 32'd0, 3'd0, 1'b1, 1'b1);
        check("stream result_count", 32'(result_count - cnt0), 32'd100);

        // Random traffic with stalls and occasional reset; held input while refused.
        iv = 1'b0;
        d  = 32'd0;
        o  = 3'd0;
        for (int i = 0; i < 400; i++) begin
            logic r;
            if (!(iv && q.size() >= DEPTH)) begin
                iv = ($urandom_range(0, 3) != 0);
                case ($urandom_range(0, 3))
                    0:       d = 32'd0;
                    1:       d = 32'hFFFF_FFFF;
                    default: d = $urandom;
                endcase
                o = 3'($urandom_range(0, 4));
            end
            r = ($urandom_range(0, 49) == 0);
            cycle(r, iv, d, o, ($urandom_range(0, 2) != 0), 1'b1);
            if (r) iv = 1'b0;
        end

        // Counter wrap: reset, then stream until 0xFFFF dequeues, then one more.
        cycle(1'b1, 1'b0, 32'd0, 3'd0, 1'b0, 1'b1);
        for (int i = 0; i < 65536; i++) begin
            cycle(1'b0, 1'b1, 32'(i), OP_ADD, 1'b1, 1'b0);
        end
        check("wrap count at max", 32'(result_count), 32'h0000_FFFF);
        compare_model();
        cycle(1'b0, 1'b0, 32'd0, 3'd0, 1'b1, 1'b1);
        check("wrap count to zero", 32'(result_count), 32'h0000_0000);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_alu_result_buffer
